// File: rtl/bcd_convert_ctrl.sv
// bcd_convert_ctrl
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble).
//   One operand bit is consumed per cycle, so a conversion takes WIDTH
//   shift cycles plus one DONE cycle.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   start  : conversion request, only looked at while idle
//   bin    : WIDTH-bit unsigned operand, captured when start is accepted
//   busy   : high from the accept edge through the DONE cycle
//   done   : one-cycle pulse, bcd/ovf just updated
//   bcd    : DIGITS packed BCD digits, ones digit in [3:0]; held until next done
//   ovf    : operand did not fit in DIGITS digits (bcd = bin mod 10^DIGITS)
module bcd_convert_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic            stk_q, stk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Add-3 correction applied independently to each digit; no carry between
  // digits since a corrected digit (<= 12) still fits in 4 bits.
  logic [BW-1:0] adj;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? (scr_q[4*i +: 4] + 4'd3)
                                                     : scr_q[4*i +: 4];
  end

  // Post-shift scratch: operand MSB enters at bit 0; the bit falling off the
  // top digit is a multiple of 10^DIGITS, hence the sticky overflow.
  logic [BW-1:0] shifted;
  logic          shift_out;
  if (BW > 1) begin : g_shift
    assign shifted = {adj[BW-2:0], op_q[WIDTH-1]};
  end else begin : g_shift1
    assign shifted = op_q[WIDTH-1];
  end
  assign shift_out = adj[BW-1];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    scr_d   = scr_q;
    stk_d   = stk_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = bin;
          scr_d   = '0;
          stk_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        op_d  = op_q << 1;
        scr_d = shifted;
        stk_d = stk_q | shift_out;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Final step: publish the result on the edge that enters DONE.
          bcd_d   = shifted;
          ovf_d   = stk_q | shift_out;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      scr_q   <= '0;
      stk_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      scr_q   <= scr_d;
      stk_q   <= stk_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule
